// File: rtl/vscpu_param_core.sv
// vscpu_param_core
//   Parametrised very-simple multicycle CPU. An 8-op / 16-instruction
//   memory-to-memory ISA: every operand lives in RAM and there is no
//   register file. Each instruction is a short sequence of RAM accesses
//   (fetch, operand reads, optional indirect read, write-back). Every
//   access uses a req/rdy handshake, so RAM latency can vary.
//
//   Instruction word layout:
//     op = IW[DW-1:DW-4]
//     A  = IW[2*AW-1:AW]
//     B  = IW[AW-1:0]
//   op[0] selects the immediate form, in which B is zero-extended.
//
// Parameters
//   DW    data / instruction width (must satisfy DW >= 4 + 2*AW)
//   AW    address width (PC, A and B fields)
//   CNTW  width of the retired-instruction counter (wraps)
//
// Ports
//   clk        clock; all state changes on posedge
//   rst        synchronous active-high reset
//   mem_req    access request; addr/we/wdata held stable until mem_rdy
//   mem_we     1 = write, 0 = read
//   mem_addr   access address
//   mem_wdata  write data
//   mem_rdy    access completes in any cycle where mem_req && mem_rdy
//   mem_rdata  read data, valid only in the completing cycle
//   halted     core stopped on a self-loop branch
//   retired    count of completed instructions
module vscpu_param_core #(
  parameter int DW   = 32,
  parameter int AW   = 14,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_rdy,
  input  logic [DW-1:0]   mem_rdata,
  output logic            halted,
  output logic [CNTW-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_RD_A,
    S_RD_B,
    S_RD_I,
    S_WR,
    S_HALT
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_SRL  = 3'd2;
  localparam logic [2:0] OP_LT   = 3'd3;
  localparam logic [2:0] OP_CP   = 3'd4;
  localparam logic [2:0] OP_CPI  = 3'd5;
  localparam logic [2:0] OP_BZJ  = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  localparam logic [AW-1:0]   PC_ONE  = AW'(1);
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  localparam logic [DW-1:0]   D_ONE   = DW'(1);
  localparam logic [DW-1:0]   SH_DW   = DW'(DW);
  localparam logic [DW:0]     SH_2DW  = (DW+1)'(2*DW);

  function automatic logic [DW-1:0] zext(input logic [AW-1:0] v);
    return {{(DW-AW){1'b0}}, v};
  endfunction

  // Amounts below DW shift right; amounts in [DW, 2*DW) shift left by
  // (amount - DW); anything larger produces zero. The extra top bit on
  // the second compare keeps 2*DW representable.
  function automatic logic [DW-1:0] srl_op(input logic [DW-1:0] x,
                                           input logic [DW-1:0] s);
    if (s < SH_DW)
      return x >> s;
    else if ({1'b0, s} < SH_2DW)
      return x << (s - SH_DW);
    else
      return '0;
  endfunction

  function automatic logic [DW-1:0] alu(input logic [2:0]    op,
                                        input logic [DW-1:0] x,
                                        input logic [DW-1:0] y);
    logic [DW-1:0] r;
    case (op)
      OP_ADD:  r = x + y;
      OP_NAND: r = ~(x & y);
      OP_SRL:  r = srl_op(x, y);
      OP_LT:   r = (x < y) ? D_ONE : '0;
      OP_MUL:  r = x * y;
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t          state, state_n;
  logic [AW-1:0]   pc, pc_n;
  logic [2:0]      op_r, op_n;
  logic            imm_r, imm_n;
  logic [AW-1:0]   fa_r, fa_n, fb_r, fb_n;
  logic [DW-1:0]   a_val, a_n;
  logic            req_n, we_n, halted_n;
  logic [AW-1:0]   addr_n;
  logic [DW-1:0]   wdata_n;
  logic [CNTW-1:0] retired_n;

  logic            done;
  logic [2:0]      iw_op;
  logic            iw_imm;
  logic [AW-1:0]   iw_a, iw_b;
  logic            br_en, br_taken;
  logic [AW-1:0]   br_tgt;
  logic [DW-1:0]   bzji_sum;

  assign done   = mem_req && mem_rdy;
  assign iw_op  = mem_rdata[DW-1:DW-3];
  assign iw_imm = mem_rdata[DW-4];
  assign iw_a   = mem_rdata[2*AW-1:AW];
  assign iw_b   = mem_rdata[AW-1:0];

  // Next-state and registered-output logic. A completing access
  // directly loads the next access, so the new request is visible the
  // cycle after completion.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    op_n      = op_r;
    imm_n     = imm_r;
    fa_n      = fa_r;
    fb_n      = fb_r;
    a_n       = a_val;
    req_n     = mem_req;
    we_n      = mem_we;
    addr_n    = mem_addr;
    wdata_n   = mem_wdata;
    halted_n  = halted;
    retired_n = retired;
    br_en     = 1'b0;
    br_taken  = 1'b0;
    br_tgt    = '0;
    bzji_sum  = '0;

    case (state)
      S_FETCH: begin
        if (!mem_req) begin
          // Only reached right after reset: issue the first fetch.
          req_n  = 1'b1;
          we_n   = 1'b0;
          addr_n = pc;
        end else if (mem_rdy) begin
          op_n  = iw_op;
          imm_n = iw_imm;
          fa_n  = iw_a;
          fb_n  = iw_b;
          if (iw_op == OP_CP && iw_imm) begin
            state_n = S_WR;
            we_n    = 1'b1;
            addr_n  = iw_a;
            wdata_n = zext(iw_b);
          end else if (!iw_imm && (iw_op == OP_CP || iw_op == OP_CPI)) begin
            state_n = S_RD_B;
            we_n    = 1'b0;
            addr_n  = iw_b;
          end else begin
            state_n = S_RD_A;
            we_n    = 1'b0;
            addr_n  = iw_a;
          end
        end
      end

      S_RD_A: begin
        if (done) begin
          a_n = mem_rdata;
          if (imm_r && op_r == OP_BZJ) begin
            bzji_sum = mem_rdata + zext(fb_r);
            br_en    = 1'b1;
            br_taken = 1'b1;
            br_tgt   = bzji_sum[AW-1:0];
          end else if (imm_r && op_r != OP_CPI) begin
            state_n = S_WR;
            we_n    = 1'b1;
            addr_n  = fa_r;
            wdata_n = alu(op_r, mem_rdata, zext(fb_r));
          end else begin
            state_n = S_RD_B;
            addr_n  = fb_r;
          end
        end
      end

      S_RD_B: begin
        if (done) begin
          case (op_r)
            OP_CP: begin
              state_n = S_WR;
              we_n    = 1'b1;
              addr_n  = fa_r;
              wdata_n = mem_rdata;
            end
            OP_CPI: begin
              if (imm_r) begin
                // Store *B through the pointer read from A.
                state_n = S_WR;
                we_n    = 1'b1;
                addr_n  = a_val[AW-1:0];
                wdata_n = mem_rdata;
              end else begin
                state_n = S_RD_I;
                addr_n  = mem_rdata[AW-1:0];
              end
            end
            OP_BZJ: begin
              br_en    = 1'b1;
              br_taken = (mem_rdata == '0);
              br_tgt   = a_val[AW-1:0];
            end
            default: begin
              state_n = S_WR;
              we_n    = 1'b1;
              addr_n  = fa_r;
              wdata_n = alu(op_r, a_val, mem_rdata);
            end
          endcase
        end
      end

      S_RD_I: begin
        if (done) begin
          state_n = S_WR;
          we_n    = 1'b1;
          addr_n  = fa_r;
          wdata_n = mem_rdata;
        end
      end

      S_WR: begin
        if (done) begin
          retired_n = retired + CNT_ONE;
          pc_n      = pc + PC_ONE;
          state_n   = S_FETCH;
          we_n      = 1'b0;
          addr_n    = pc + PC_ONE;
        end
      end

      S_HALT: begin
        req_n = 1'b0;
        we_n  = 1'b0;
      end

      default: begin
        state_n = S_FETCH;
        req_n   = 1'b0;
        we_n    = 1'b0;
      end
    endcase

    // Branches retire on their last read; a taken branch onto itself
    // is the halt idiom.
    if (br_en) begin
      retired_n = retired + CNT_ONE;
      if (br_taken && br_tgt == pc) begin
        state_n  = S_HALT;
        halted_n = 1'b1;
        req_n    = 1'b0;
        we_n     = 1'b0;
      end else begin
        pc_n    = br_taken ? br_tgt : pc + PC_ONE;
        state_n = S_FETCH;
        we_n    = 1'b0;
        addr_n  = pc_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
      retired   <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      mem_req   <= req_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      halted    <= halted_n;
      retired   <= retired_n;
    end
  end

  // Decoded fields and the A operand are only meaningful inside an
  // instruction, so they carry no reset.
  always_ff @(posedge clk) begin
    op_r  <= op_n;
    imm_r <= imm_n;
    fa_r  <= fa_n;
    fb_r  <= fb_n;
    a_val <= a_n;
  end

endmodule
